// File: rtl/key_entry_ctrl.sv
// rtl/key_entry_ctrl.sv - alarm clock keypad entry sequencer
// Turns key presses into shift/load strobes and display selects, aborting stale entries.
module key_entry_ctrl #(
  parameter logic [3:0] NOKEY       = 4'd10,
  parameter logic [3:0] ALARM_KEY   = 4'd11,
  parameter logic [3:0] TIME_KEY    = 4'd12,
  parameter int         TIMEOUT_SEC = 10
) (
  input  logic       reset,
  input  logic       clock,
  input  logic       one_second,
  input  logic [3:0] key,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_new_time,
  output logic       show_a,
  output logic [2:0] digit_cnt
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    SHOW_ALARM,
    KEY_STORE,
    KEY_WAIT,
    SET_ALARM,
    SET_TIME
  } state_t;

  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_SEC - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] key_prev;
  logic [3:0] sec_cnt;
  logic       press;
  logic       is_digit;
  logic       entry_full;
  logic       timeout_tick;

  // key_prev resets to NOKEY, so a key held across reset release is a press
  assign press        = (key != NOKEY) && (key_prev == NOKEY);
  assign is_digit     = (key <= 4'd9);
  assign entry_full   = (digit_cnt == 3'd4);
  assign timeout_tick = one_second && (sec_cnt == TIMEOUT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      SHOW_TIME: begin
        if (press && is_digit) begin
          state_next = KEY_STORE;
        end else if (press && (key == ALARM_KEY)) begin
          state_next = SHOW_ALARM;
        end
      end
      SHOW_ALARM: begin
        if (key != ALARM_KEY) begin
          state_next = SHOW_TIME;
        end
      end
      KEY_STORE: state_next = KEY_WAIT;
      KEY_WAIT: begin
        // a press takes priority over a coincident timeout tick
        if (press && is_digit) begin
          state_next = KEY_STORE;
        end else if (press && (key == ALARM_KEY)) begin
          state_next = entry_full ? SET_ALARM : SHOW_TIME;
        end else if (press && (key == TIME_KEY)) begin
          state_next = entry_full ? SET_TIME : SHOW_TIME;
        end else if (timeout_tick) begin
          state_next = SHOW_TIME;
        end
      end
      SET_ALARM: state_next = SHOW_TIME;
      SET_TIME:  state_next = SHOW_TIME;
      default:   state_next = SHOW_TIME;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= SHOW_TIME;
      key_prev      <= NOKEY;
      sec_cnt       <= 4'd0;
      digit_cnt     <= 3'd0;
      shift         <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
      show_new_time <= 1'b0;
      show_a        <= 1'b0;
    end else begin
      state         <= state_next;
      key_prev      <= key;
      shift         <= (state_next == KEY_STORE);
      load_new_a    <= (state_next == SET_ALARM);
      load_new_c    <= (state_next == SET_TIME);
      show_new_time <= (state_next == KEY_STORE) || (state_next == KEY_WAIT);
      show_a        <= (state_next == SHOW_ALARM);

      if (state == KEY_STORE) begin
        digit_cnt <= entry_full ? 3'd4 : digit_cnt + 3'd1;
        sec_cnt   <= 4'd0;
      end else if ((state == KEY_WAIT) && one_second && (state_next == KEY_WAIT)) begin
        sec_cnt <= sec_cnt + 4'd1;
      end

      // clearing on the way back means digit_cnt is already 0 in SHOW_TIME
      if (state_next == SHOW_TIME) begin
        digit_cnt <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// tb/tb_key_entry_ctrl.sv - scoreboard bench for key_entry_ctrl
// Entry-level model predicts strobes; a negedge monitor pops and compares them.
module tb_key_entry_ctrl;

  localparam logic [3:0] NOKEY       = 4'd10;
  localparam logic [3:0] ALARM_KEY   = 4'd11;
  localparam logic [3:0] TIME_KEY    = 4'd12;
  localparam int         TIMEOUT_SEC = 10;

  localparam int EV_SHIFT = 16 + 8;
  localparam int EV_LOADA = 32;
  localparam int EV_LOADC = 48;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       shift;
  logic       load_new_a;
  logic       load_new_c;
  logic       show_new_time;
  logic       show_a;
  logic [2:0] digit_cnt;

  key_entry_ctrl #(
    .NOKEY(NOKEY), .ALARM_KEY(ALARM_KEY), .TIME_KEY(TIME_KEY), .TIMEOUT_SEC(TIMEOUT_SEC)
  ) dut (
    .reset(reset), .clock(clock), .one_second(one_second), .key(key),
    .shift(shift), .load_new_a(load_new_a), .load_new_c(load_new_c),
    .show_new_time(show_new_time), .show_a(show_a), .digit_cnt(digit_cnt)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  typedef enum {M_IDLE, M_ENTRY, M_AVIEW} mode_t;
  mode_t mode  = M_IDLE;
  int    cnt   = 0;
  int    ticks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // entry rules: digits accumulate (last four kept), ALARM/TIME commit only a full entry
  task automatic model_press(input logic [3:0] k);
    case (mode)
      M_IDLE: begin
        if (k <= 4'd9) begin
          exp_q.push_back(EV_SHIFT + 0);
          cnt = 1; ticks = 0; mode = M_ENTRY;
        end else if (k == ALARM_KEY) begin
          mode = M_AVIEW;
        end
      end
      M_ENTRY: begin
        if (k <= 4'd9) begin
          exp_q.push_back(EV_SHIFT + cnt);
          cnt = (cnt == 4) ? 4 : cnt + 1; ticks = 0;
        end else if (k == ALARM_KEY || k == TIME_KEY) begin
          if (cnt == 4) exp_q.push_back(k == ALARM_KEY ? EV_LOADA : EV_LOADC);
          mode = M_IDLE; cnt = 0; ticks = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_tick();
    if (mode == M_ENTRY) begin
      ticks++;
      if (ticks == TIMEOUT_SEC) begin
        mode = M_IDLE; cnt = 0; ticks = 0;
      end
    end
  endtask

  task automatic cyc(input logic [3:0] k, input logic t);
    key = k;
    one_second = t;
    @(posedge clock);
    #1;
    one_second = 1'b0;
  endtask

  task automatic check_view(input string name);
    check({name, "_show_a"}, int'(show_a), int'(mode == M_AVIEW));
    check({name, "_show_new_time"}, int'(show_new_time), int'(mode == M_ENTRY));
  endtask

  task automatic press(input logic [3:0] k, input int hold, input bit race);
    model_press(k);
    for (int i = 0; i < hold; i++) begin
      cyc(k, (i == 0) && race);
      check_view("hold");
    end
    if (mode == M_AVIEW) mode = M_IDLE;
  endtask

  // tick_mode: 0 none, 1 every cycle, 2 random
  task automatic gaps(input int n, input int tick_mode);
    logic t;
    for (int i = 0; i < n; i++) begin
      t = (tick_mode == 1) || (tick_mode == 2 && $urandom_range(0, 3) == 0);
      cyc(NOKEY, t);
      if (t) model_tick();
      check_view("gap");
      check("gap_digit_cnt", int'(digit_cnt), (mode == M_ENTRY) ? cnt : 0);
    end
  endtask

  task automatic entry(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                       input logic [3:0] d3, input int n);
    logic [3:0] ds[4];
    ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
    for (int i = 0; i < n; i++) begin
      press(ds[i], 3, 1'b0);
      gaps(1, 0);
    end
  endtask

  always @(negedge clock) begin
    int act;
    if (!reset && (shift || load_new_a || load_new_c)) begin
      if (int'(shift) + int'(load_new_a) + int'(load_new_c) > 1) act = 999;
      else if (shift) act = 16 + 8 * int'(show_new_time) + int'(digit_cnt);
      else if (load_new_a) act = EV_LOADA + 8 * int'(show_new_time);
      else act = EV_LOADC + 8 * int'(show_new_time);
      if (exp_q.size() == 0) check("unexpected_strobe", act, 0);
      else check("strobe", act, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; key = NOKEY; one_second = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", int'({shift, load_new_a, load_new_c, show_new_time, show_a, digit_cnt}), 0);
    reset = 1'b0;
    @(posedge clock); #1;
    check_view("after_reset");

    // full alarm entry
    entry(4'd1, 4'd2, 4'd3, 4'd4, 4);
    press(ALARM_KEY, 3, 1'b0); gaps(2, 0);
    // full time entry
    entry(4'd0, 4'd7, 4'd4, 4'd5, 4);
    press(TIME_KEY, 3, 1'b0); gaps(2, 0);
    // short entry aborts without a strobe
    entry(4'd1, 4'd2, 4'd0, 4'd0, 2);
    press(TIME_KEY, 2, 1'b0); gaps(2, 0);
    // plain timeout
    press(4'd5, 2, 1'b0); gaps(TIMEOUT_SEC, 1); gaps(2, 0);
    // press coincident with the last tick wins and restarts the count
    press(4'd5, 2, 1'b0); gaps(TIMEOUT_SEC - 1, 1);
    press(4'd3, 2, 1'b1); gaps(TIMEOUT_SEC - 1, 1);
    gaps(1, 1); gaps(1, 0);
    // alarm view hold and long digit hold
    press(ALARM_KEY, 20, 1'b0); gaps(2, 0);
    press(4'd8, 10, 1'b0); gaps(2, 0);
    // six digits then ALARM keeps saturating count
    entry(4'd9, 4'd9, 4'd1, 4'd2, 4); entry(4'd3, 4'd6, 4'd0, 4'd0, 2);
    press(ALARM_KEY, 2, 1'b0); gaps(1, 0);

    // asynchronous reset mid-entry
    press(4'd6, 2, 1'b0); gaps(2, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("async_reset", int'({shift, load_new_a, load_new_c, show_new_time, show_a, digit_cnt}), 0);
    mode = M_IDLE; cnt = 0; ticks = 0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check_view("post_reset");

    for (int n = 0; n < 250; n++) begin
      int r;
      logic [3:0] k;
      r = $urandom_range(0, 99);
      if (r < 70) k = 4'($urandom_range(0, 9));
      else if (r < 80) k = ALARM_KEY;
      else if (r < 90) k = TIME_KEY;
      else k = 4'($urandom_range(13, 15));
      press(k, $urandom_range(2, 6), (k <= 4'd9) && ($urandom_range(0, 3) == 0));
      gaps($urandom_range(1, 4), 2);
    end

    gaps(3, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
